// File: rtl/rng_block_reader.sv
// Reads one digest block at a time out of the FiGaRO_SHA3 RNG output memory and
// forwards it word by word on a valid/ready stream, tagging the block's final word.
module rng_block_reader #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int BASE_ADDR = 0,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    output logic              rng_enable,
    input  logic              rng_ready,
    output logic [ADDR_W-1:0] rng_addr,
    input  logic [DATA_W-1:0] rng_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              abort,
    output logic [15:0]       blk_cnt,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_ADDR = 3'd2,
        S_CAP  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [1:0]        LAT_LAST = 2'(READ_LAT - 1);

    state_t            state;
    logic              rdy_q;
    logic              fresh;
    logic              rdy_rise;
    logic              blk_start;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic [1:0]        lat_cnt;

    assign rdy_rise  = rng_ready & ~rdy_q;
    assign blk_start = (state == S_WAIT) && en && fresh && rng_ready;
    assign idx_nxt   = idx + ADDR_W'(1);
    assign state_dbg = state;

    // Stream handshake: a word transfers on a rising clk edge where out_valid and
    // out_ready are both 1; out_valid is registered and out_data/out_last hold until then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            rng_enable <= 1'b0;
            rng_addr   <= BASE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            abort      <= 1'b0;
            blk_cnt    <= 16'd0;
            fresh      <= 1'b0;
            rdy_q      <= 1'b0;
            idx        <= '0;
            lat_cnt    <= 2'd0;
        end else begin
            rng_enable <= en;
            rdy_q      <= rng_ready;
            abort      <= 1'b0;

            // A new ready edge outranks the clear caused by starting a block.
            if (rdy_rise) begin
                fresh <= 1'b1;
            end else if (blk_start) begin
                fresh <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (en) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (fresh && rng_ready) begin
                        state    <= S_ADDR;
                        idx      <= '0;
                        rng_addr <= BASE;
                        lat_cnt  <= 2'd0;
                    end
                end
                S_ADDR: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= S_CAP;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_CAP: begin
                    if (rng_ready) begin
                        out_data  <= rng_data;
                        out_valid <= 1'b1;
                        out_last  <= (idx == LAST_IDX);
                        state     <= S_OUT;
                    end else begin
                        abort <= 1'b1;
                        idx   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            blk_cnt  <= blk_cnt + 16'd1;
                            rng_addr <= BASE;
                            state    <= en ? S_WAIT : S_IDLE;
                        end else begin
                            idx      <= idx_nxt;
                            rng_addr <= BASE + idx_nxt;
                            lat_cnt  <= 2'd0;
                            state    <= en ? S_ADDR : S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    a_abort_excl: assert property (@(posedge clk) disable iff (!reset_n) !(abort && out_valid));
    a_hold_stall: assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

endmodule

// File: tb/tb_rng_block_reader.sv
// Bench for rng_block_reader: a default instance (8 words, latency 1) and a
// single-word, latency-3 instance, both checked against expected-word queues.
module tb_rng_block_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int LAT_A  = 1;
    localparam int NW_A   = 8;

    logic clk = 1'b0;
    logic reset_n;

    logic              en_a, rng_enable_a, rng_ready_a, out_valid_a, out_ready_a;
    logic              out_last_a, abort_a;
    logic [ADDR_W-1:0] rng_addr_a;
    logic [DATA_W-1:0] rng_data_a, out_data_a;
    logic [15:0]       blk_cnt_a;
    logic [2:0]        state_a;

    logic              en_b, rng_enable_b, rng_ready_b, out_valid_b, out_ready_b;
    logic              out_last_b, abort_b;
    logic [ADDR_W-1:0] rng_addr_b;
    logic [DATA_W-1:0] rng_data_b, out_data_b;
    logic [15:0]       blk_cnt_b;
    logic [2:0]        state_b;

    logic [DATA_W-1:0] seed_b, p0_b, p1_b;

    int vectors     = 0;
    int miscompares = 0;
    logic [DATA_W:0] exp_q[$];
    logic [DATA_W:0] exp_q_b[$];
    int   cyc = 0, hs_a = 0, hs_b = 0, abort_a_cnt = 0, last_hs = -1;
    bit   tp_chk = 1'b0;

    rng_block_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NW_A),
                       .BASE_ADDR(0), .READ_LAT(LAT_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .en(en_a), .rng_enable(rng_enable_a),
        .rng_ready(rng_ready_a), .rng_addr(rng_addr_a), .rng_data(rng_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_last(out_last_a), .abort(abort_a), .blk_cnt(blk_cnt_a), .state_dbg(state_a)
    );

    rng_block_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(1),
                       .BASE_ADDR(0), .READ_LAT(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .en(en_b), .rng_enable(rng_enable_b),
        .rng_ready(rng_ready_b), .rng_addr(rng_addr_b), .rng_data(rng_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_last(out_last_b), .abort(abort_b), .blk_cnt(blk_cnt_b), .state_dbg(state_b)
    );

    // clock / reset-independent RNG memory models
    always #5 clk = ~clk;

    always @(posedge clk) rng_data_a <= 32'hA500_0000 + {22'd0, rng_addr_a};

    always @(posedge clk) begin
        p0_b       <= seed_b + {22'd0, rng_addr_b};
        p1_b       <= p0_b;
        rng_data_b <= p1_b;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every accepted word is compared against the head of its queue
    always @(negedge clk) begin
        logic [DATA_W:0] e;
        cyc++;
        if (out_valid_a && out_ready_a) begin
            hs_a++;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 'x;
            check("a_word", {out_last_a, out_data_a}, e);
            if (tp_chk && last_hs >= 0) check("a_thruput", cyc - last_hs, LAT_A + 2);
            last_hs = cyc;
        end
        if (abort_a) begin
            abort_a_cnt++;
            check("a_abort_excl", out_valid_a, 0);
        end
        if (out_valid_b && out_ready_b) begin
            hs_b++;
            if (exp_q_b.size() != 0) e = exp_q_b.pop_front();
            else e = 'x;
            check("b_word", {out_last_b, out_data_b}, e);
        end
        if (abort_b) check("b_abort_excl", out_valid_b, 0);
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_block_a(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == NW_A - 1), 32'hA500_0000 + 32'(i)});
    endtask

    task automatic ready_edge_a();
        rng_ready_a = 1'b0;
        tick(1);
        rng_ready_a = 1'b1;
    endtask

    task automatic drain(input bit sel_b, input int budget);
        int n = 0;
        while (((sel_b ? exp_q_b.size() : exp_q.size()) != 0) && n < budget) begin
            tick(1);
            n++;
        end
        check(sel_b ? "b_drain" : "a_drain", sel_b ? exp_q_b.size() : exp_q.size(), 0);
    endtask

    task automatic wait_valid_a(input int budget);
        int n = 0;
        while (!out_valid_a && n < budget) begin
            tick(1);
            n++;
        end
        check("a_valid_wait", out_valid_a, 1);
    endtask

    task automatic handshake_a();
        out_ready_a = 1'b1;
        tick(1);
        out_ready_a = 1'b0;
    endtask

    task automatic accept_word_a(input int w, input int stall);
        wait_valid_a(50);
        for (int s = 0; s < stall; s++) begin
            tick(1);
            check("a_stall_data", out_data_a, 32'hA500_0000 + 32'(w));
            check("a_stall_last", out_last_a, (w == NW_A - 1));
            check("a_stall_valid", out_valid_a, 1);
        end
        handshake_a();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        int h, a0;
        reset_n = 1'b0;
        en_a = 1'b0; rng_ready_a = 1'b0; out_ready_a = 1'b0;
        en_b = 1'b0; rng_ready_b = 1'b0; out_ready_b = 1'b0;
        seed_b = 32'h0;
        tick(3);
        check("rst_valid", out_valid_a, 0);
        check("rst_data", out_data_a, 0);
        check("rst_last", out_last_a, 0);
        check("rst_abort", abort_a, 0);
        check("rst_blk", blk_cnt_a, 0);
        check("rst_rng_en", rng_enable_a, 0);
        check("rst_addr", rng_addr_a, 0);
        check("rst_state", state_a, 0);
        reset_n = 1'b1;
        tick(2);

        // full block, out_ready held high
        en_a = 1'b1; out_ready_a = 1'b1;
        tick(3);
        check("a_rng_en_on", rng_enable_a, 1);
        check("a_state_wait", state_a, 1);
        push_block_a(NW_A);
        tp_chk = 1'b1; last_hs = -1;
        rng_ready_a = 1'b1;
        drain(0, 200);
        tp_chk = 1'b0;
        tick(1);
        check("a_blk1", blk_cnt_a, 1);

        // ready held high: no new block without a fresh edge
        h = hs_a;
        tick(30);
        check("a_no_reissue", hs_a, h);
        check("a_quiet_valid", out_valid_a, 0);
        check("a_quiet_state", state_a, 1);
        push_block_a(NW_A);
        ready_edge_a();
        drain(0, 200);
        tick(1);
        check("a_blk2", blk_cnt_a, 2);

        // back-pressure on the third word
        out_ready_a = 1'b0;
        push_block_a(NW_A);
        ready_edge_a();
        for (int w = 0; w < NW_A; w++) accept_word_a(w, (w == 2) ? 5 : 0);
        tick(1);
        check("a_blk3", blk_cnt_a, 3);

        // ready drops before the fifth word is captured
        push_block_a(4);
        ready_edge_a();
        for (int w = 0; w < 4; w++) accept_word_a(w, 0);
        rng_ready_a = 1'b0;
        a0 = abort_a_cnt;
        h  = hs_a;
        tick(8);
        check("a_abort_pulses", abort_a_cnt - a0, 1);
        check("a_abort_no_words", hs_a, h);
        check("a_abort_blk", blk_cnt_a, 3);
        check("a_abort_state", state_a, 1);
        push_block_a(NW_A);
        out_ready_a = 1'b1;
        rng_ready_a = 1'b1;
        drain(0, 200);
        tick(1);
        check("a_blk4", blk_cnt_a, 4);

        // en falls while the second word is pending
        out_ready_a = 1'b0;
        push_block_a(2);
        ready_edge_a();
        wait_valid_a(50);
        handshake_a();
        wait_valid_a(50);
        en_a = 1'b0;
        check("a_rng_en_lag", rng_enable_a, 1);
        tick(1);
        check("a_rng_en_off", rng_enable_a, 0);
        check("a_pending_valid", out_valid_a, 1);
        check("a_pending_data", out_data_a, 32'hA500_0001);
        handshake_a();
        check("a_stop_idle", state_a, 0);
        h = hs_a;
        tick(10);
        check("a_stop_quiet", hs_a, h);
        check("a_stop_blk", blk_cnt_a, 4);
        en_a = 1'b1; out_ready_a = 1'b1;
        push_block_a(NW_A);
        ready_edge_a();
        drain(0, 200);
        tick(1);
        check("a_blk5", blk_cnt_a, 5);
        en_a = 1'b0; rng_ready_a = 1'b0;
        tick(2);

        // single-word blocks with latency 3, then an asynchronous reset mid-block
        en_b = 1'b1; out_ready_b = 1'b1;
        seed_b = 32'h1111_0000;
        exp_q_b.push_back({1'b1, 32'h1111_0000});
        tick(2);
        rng_ready_b = 1'b1;
        drain(1, 100);
        tick(1);
        check("b_blk1", blk_cnt_b, 1);
        seed_b = 32'h2222_0000;
        exp_q_b.push_back({1'b1, 32'h2222_0000});
        rng_ready_b = 1'b0;
        tick(1);
        rng_ready_b = 1'b1;
        drain(1, 100);
        tick(1);
        check("b_blk2", blk_cnt_b, 2);

        seed_b = 32'h3333_0000;
        rng_ready_b = 1'b0;
        tick(1);
        rng_ready_b = 1'b1;
        tick(3);
        check("b_midblk_state", state_b, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("b_rst_valid", out_valid_b, 0);
        check("b_rst_data", out_data_b, 0);
        check("b_rst_last", out_last_b, 0);
        check("b_rst_blk", blk_cnt_b, 0);
        check("b_rst_rng_en", rng_enable_b, 0);
        check("b_rst_addr", rng_addr_b, 0);
        check("b_rst_state", state_b, 0);
        check("a_rst_blk", blk_cnt_a, 0);
        rng_ready_b = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check("b_rng_en_after_rst", rng_enable_b, 1);
        seed_b = 32'h4444_0000;
        exp_q_b.push_back({1'b1, 32'h4444_0000});
        rng_ready_b = 1'b1;
        drain(1, 100);
        tick(1);
        check("b_blk_after_rst", blk_cnt_b, 1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
